// File: rtl/flappy_if.sv
// Renderer bus: VGA scan position, game-physics object positions in, pixel colour and game status out.
// The master side is the timing/physics producer, the slave side is the renderer.
interface flappy_if #(
  parameter int NUM_PIPES = 2,
  parameter int SCORE_W   = 16
);
  logic                    bright;
  logic [9:0]              hCount;
  logic [9:0]              vCount;
  logic [9:0]              BirdX;
  logic [9:0]              BirdY;
  logic [10*NUM_PIPES-1:0] PipeX;
  logic [10*NUM_PIPES-1:0] PipeY;
  logic [11:0]             rgb;
  logic [SCORE_W-1:0]      score;
  logic                    collision;
  logic                    frame_done;

  modport master (
    output bright, hCount, vCount, BirdX, BirdY, PipeX, PipeY,
    input  rgb, score, collision, frame_done
  );

  modport slave (
    input  bright, hCount, vCount, BirdX, BirdY, PipeX, PipeY,
    output rgb, score, collision, frame_done
  );
endinterface

// File: rtl/flappy_renderer.sv
// Pixel painter for background, NUM_PIPES pipe pairs and the bird, with per-frame collision
// detection, per-pipe pass scoring and a frame-end strobe. All outputs are registered.
module flappy_renderer #(
  parameter int NUM_PIPES   = 2,
  parameter int PIPE_HALF_W = 50,
  parameter int GAP_H       = 100,
  parameter int BIRD_HALF   = 10,
  parameter int V_START     = 35,
  parameter int V_END       = 515,
  parameter int SCORE_W     = 16
) (
  input logic     clk,
  input logic     reset,
  flappy_if.slave bus
);

  localparam logic [10:0]        PHW       = 11'(PIPE_HALF_W);
  localparam logic [10:0]        GAP       = 11'(GAP_H);
  localparam logic [10:0]        BH        = 11'(BIRD_HALF);
  localparam logic [10:0]        VS        = 11'(V_START);
  localparam logic [10:0]        VE        = 11'(V_END);
  localparam logic [10:0]        COORD_MAX = 11'd1023;
  localparam logic [SCORE_W+3:0] SCORE_MAX = {4'd0, {SCORE_W{1'b1}}};

  logic [11:0]          rgb_q, rgb_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 collision_q, collision_d;
  logic                 frame_done_q, frame_done_d;
  logic                 pending_q, pending_d;
  logic [NUM_PIPES-1:0] passed_q, passed_d;

  logic [10:0]          h_ext, v_ext, bx, by, bird_left;
  logic [10:0]          px, py, p_left, p_right, low_top;
  logic                 bird_hit, pipe_any, edge_hit, frame_end, coll_set;
  logic [NUM_PIPES-1:0] pass_now;
  logic [3:0]           pass_cnt;
  logic [SCORE_W+3:0]   score_sum;

  // All zone geometry is 11-bit so pipe/bird bounds never wrap around the screen edge.
  always_comb begin
    h_ext     = {1'b0, bus.hCount};
    v_ext     = {1'b0, bus.vCount};
    bx        = {1'b0, bus.BirdX};
    by        = {1'b0, bus.BirdY};
    bird_left = (bx >= BH) ? (bx - BH) : 11'd0;
    bird_hit  = (h_ext + BH >= bx) && (h_ext <= bx + BH) &&
                (v_ext + BH >= by) && (v_ext <= by + BH);

    px       = 11'd0;
    py       = 11'd0;
    p_left   = 11'd0;
    p_right  = 11'd0;
    low_top  = 11'd0;
    pipe_any = 1'b0;
    pass_now = '0;
    pass_cnt = 4'd0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      px       = {1'b0, bus.PipeX[10*i +: 10]};
      py       = {1'b0, bus.PipeY[10*i +: 10]};
      p_left   = (px >= PHW) ? (px - PHW) : 11'd0;
      p_right  = px + PHW;
      low_top  = py + GAP;
      pipe_any = pipe_any | ((h_ext >= p_left) && (h_ext <= p_right) &&
                             ((v_ext <= py) || ((low_top <= COORD_MAX) && (v_ext >= low_top))));
      // A pipe fully left of the bird counts once; moving back right re-arms it.
      pass_now[i] = (p_right < bird_left);
      pass_cnt    = pass_cnt + {3'd0, (pass_now[i] & ~passed_q[i])};
    end

    frame_end = (bus.vCount == 10'(V_END)) && (bus.hCount == 10'd0);
    edge_hit  = (by < VS + BH) || (by + BH >= VE);
    coll_set  = pending_q | edge_hit;

    rgb_d = (!bus.bright) ? 12'h000 :
            bird_hit      ? 12'hFFF :
            pipe_any      ? 12'h0F0 : 12'hF00;

    pending_d    = frame_end ? 1'b0 : (pending_q | (bus.bright & bird_hit & pipe_any));
    collision_d  = collision_q | (frame_end & coll_set);
    frame_done_d = frame_end;
    passed_d     = frame_end ? pass_now : passed_q;

    score_sum = {4'd0, score_q} + {{SCORE_W{1'b0}}, pass_cnt};
    // A collision detected at this frame end suppresses any pass scored in the same frame.
    score_d   = (frame_end && !collision_q && !coll_set) ?
                ((score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0]) :
                score_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q        <= 12'h000;
      score_q      <= '0;
      collision_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pending_q    <= 1'b0;
      passed_q     <= '0;
    end else begin
      rgb_q        <= rgb_d;
      score_q      <= score_d;
      collision_q  <= collision_d;
      frame_done_q <= frame_done_d;
      pending_q    <= pending_d;
      passed_q     <= passed_d;
    end
  end

  assign bus.rgb        = rgb_q;
  assign bus.score      = score_q;
  assign bus.collision  = collision_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_flappy_renderer.sv
// Directed bench for flappy_renderer: colour probes from a vector table plus hand-written
// multi-cycle sequences for scoring, collision, edge hits and mid-frame reset.
module tb_flappy_renderer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flappy_if #(.NUM_PIPES(2), .SCORE_W(16)) bus ();
  flappy_if #(.NUM_PIPES(2), .SCORE_W(2))  bus2 ();

  flappy_renderer #(.NUM_PIPES(2), .SCORE_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  // Narrow-score twin fed the same stimulus, to exercise saturation.
  flappy_renderer #(.NUM_PIPES(2), .SCORE_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  assign bus2.bright = bus.bright;
  assign bus2.hCount = bus.hCount;
  assign bus2.vCount = bus.vCount;
  assign bus2.BirdX  = bus.BirdX;
  assign bus2.BirdY  = bus.BirdY;
  assign bus2.PipeX  = bus.PipeX;
  assign bus2.PipeY  = bus.PipeY;

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        br;
    logic [11:0] rgb;
  } probe_t;

  probe_t tbl [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input int idx, input logic [9:0] x, input logic [9:0] y);
    bus.PipeX[10*idx +: 10] = x;
    bus.PipeY[10*idx +: 10] = y;
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic br);
    bus.hCount = h;
    bus.vCount = v;
    bus.bright = br;
  endtask

  task automatic do_frame(input string tag, input logic [31:0] exp_score,
                          input logic exp_coll, input logic [31:0] exp_score2);
    pix(10'd0, 10'd515, 1'b0);
    step();
    chk({tag, " frame_done"}, 32'(bus.frame_done), 32'd1);
    chk({tag, " score"}, 32'(bus.score), exp_score);
    chk({tag, " collision"}, 32'(bus.collision), 32'(exp_coll));
    chk({tag, " sat_frame_done"}, 32'(bus2.frame_done), 32'd1);
    chk({tag, " sat_score"}, 32'(bus2.score), exp_score2);
    chk({tag, " sat_collision"}, 32'(bus2.collision), 32'(exp_coll));
    pix(10'd1, 10'd515, 1'b0);
    step();
    chk({tag, " frame_done_drop"}, 32'(bus.frame_done), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pix(10'd0, 10'd0, 1'b0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{10'd20,  10'd0,    10'd100, 1'b1, 12'h0F0};
    tbl[1]  = '{10'd20,  10'd70,   10'd100, 1'b1, 12'h0F0};
    tbl[2]  = '{10'd20,  10'd71,   10'd100, 1'b1, 12'hF00};
    tbl[3]  = '{10'd20,  10'd1000, 10'd100, 1'b1, 12'hF00};
    tbl[4]  = '{10'd20,  10'd1023, 10'd100, 1'b1, 12'hF00};
    tbl[5]  = '{10'd20,  10'd40,   10'd250, 1'b1, 12'hF00};
    tbl[6]  = '{10'd20,  10'd40,   10'd300, 1'b1, 12'h0F0};
    tbl[7]  = '{10'd400, 10'd900,  10'd940, 1'b1, 12'h0F0};
    tbl[8]  = '{10'd400, 10'd900,  10'd1000,1'b1, 12'hF00};
    tbl[9]  = '{10'd400, 10'd400,  10'd150, 1'b1, 12'h0F0};
    tbl[10] = '{10'd400, 10'd400,  10'd250, 1'b1, 12'hF00};
    tbl[11] = '{10'd400, 10'd400,  10'd300, 1'b1, 12'h0F0};
    tbl[12] = '{10'd400, 10'd451,  10'd150, 1'b1, 12'hF00};
    tbl[13] = '{10'd400, 10'd450,  10'd150, 1'b1, 12'h0F0};
    tbl[14] = '{10'd400, 10'd349,  10'd150, 1'b1, 12'hF00};
    tbl[15] = '{10'd400, 10'd350,  10'd150, 1'b1, 12'h0F0};
    tbl[16] = '{10'd400, 10'd400,  10'd299, 1'b1, 12'hF00};
    tbl[17] = '{10'd400, 10'd200,  10'd240, 1'b1, 12'hFFF};
    tbl[18] = '{10'd400, 10'd210,  10'd250, 1'b1, 12'hFFF};
    tbl[19] = '{10'd400, 10'd211,  10'd240, 1'b1, 12'hF00};
    tbl[20] = '{10'd400, 10'd200,  10'd229, 1'b1, 12'hF00};
    tbl[21] = '{10'd400, 10'd400,  10'd150, 1'b0, 12'h000};

    reset     = 1'b1;
    bus.BirdX = 10'd200;
    bus.BirdY = 10'd240;
    bus.PipeX = '0;
    bus.PipeY = '0;
    set_pipe(0, 10'd400, 10'd200);
    set_pipe(1, 10'd900, 10'd950);
    pix(10'd0, 10'd0, 1'b0);
    step();
    step();
    chk("reset rgb", 32'(bus.rgb), 32'h000);
    chk("reset score", 32'(bus.score), 32'd0);
    chk("reset collision", 32'(bus.collision), 32'd0);
    chk("reset frame_done", 32'(bus.frame_done), 32'd0);
    reset = 1'b0;
    step();
    chk("idle rgb", 32'(bus.rgb), 32'h000);

    // Colour zones, one-cycle latency.
    for (int i = 0; i < 22; i++) begin
      set_pipe(0, tbl[i].px, 10'd200);
      pix(tbl[i].h, tbl[i].v, tbl[i].br);
      step();
      chk($sformatf("rgb[%0d]", i), 32'(bus.rgb), 32'(tbl[i].rgb));
      chk($sformatf("sat_rgb[%0d]", i), 32'(bus2.rgb), 32'(tbl[i].rgb));
    end
    do_frame("no_pass", 32'd0, 1'b0, 32'd0);

    // Pipe walks left past the bird (bird left edge 190, pipe right edge = x+50).
    for (int x = 300; x >= 130; x -= 10) begin
      set_pipe(0, 10'(x), 10'd200);
      do_frame($sformatf("walk%0d", x), (x <= 130) ? 32'd1 : 32'd0, 1'b0, (x <= 130) ? 32'd1 : 32'd0);
    end
    do_frame("hold", 32'd1, 1'b0, 32'd1);
    set_pipe(0, 10'd600, 10'd200);
    do_frame("respawn", 32'd1, 1'b0, 32'd1);
    set_pipe(0, 10'd130, 10'd200);
    do_frame("second_pass", 32'd2, 1'b0, 32'd2);
    set_pipe(0, 10'd600, 10'd200);
    do_frame("respawn2", 32'd2, 1'b0, 32'd2);
    set_pipe(0, 10'd130, 10'd200);
    set_pipe(1, 10'd100, 10'd950);
    do_frame("double_pass", 32'd4, 1'b0, 32'd3);
    set_pipe(0, 10'd600, 10'd200);
    set_pipe(1, 10'd900, 10'd950);
    do_frame("respawn3", 32'd4, 1'b0, 32'd3);

    // Bird inside the upper pipe: collision latched only at frame end.
    bus.BirdX = 10'd400;
    bus.BirdY = 10'd150;
    set_pipe(0, 10'd400, 10'd200);
    for (int v = 145; v <= 155; v++) begin
      for (int h = 395; h <= 405; h++) begin
        pix(10'(h), 10'(v), 1'b1);
        step();
      end
    end
    chk("overlap rgb", 32'(bus.rgb), 32'hFFF);
    chk("pending hidden", 32'(bus.collision), 32'd0);
    do_frame("pipe_hit", 32'd4, 1'b1, 32'd3);
    set_pipe(0, 10'd300, 10'd200);
    do_frame("pass_after_hit", 32'd4, 1'b1, 32'd3);

    do_reset();
    chk("rereset score", 32'(bus.score), 32'd0);
    chk("rereset collision", 32'(bus.collision), 32'd0);

    // Screen-edge collisions: hit when BirdY < 45 or BirdY >= 505.
    bus.BirdX = 10'd200;
    set_pipe(0, 10'd600, 10'd200);
    bus.BirdY = 10'd40;
    do_frame("top_edge", 32'd0, 1'b1, 32'd0);
    do_reset();
    bus.BirdY = 10'd45;
    do_frame("top_ok", 32'd0, 1'b0, 32'd0);
    bus.BirdY = 10'd503;
    do_frame("bottom_ok", 32'd0, 1'b0, 32'd0);
    bus.BirdY = 10'd505;
    do_frame("bottom_edge", 32'd0, 1'b1, 32'd0);
    do_reset();

    // Mid-frame reset drops the pending overlap; without reset it latches.
    bus.BirdX = 10'd60;
    bus.BirdY = 10'd150;
    set_pipe(0, 10'd20, 10'd200);
    pix(10'd60, 10'd150, 1'b1);
    step();
    chk("clamp overlap rgb", 32'(bus.rgb), 32'hFFF);
    do_reset();
    do_frame("reset_discard", 32'd0, 1'b0, 32'd0);
    pix(10'd60, 10'd150, 1'b1);
    step();
    do_frame("no_reset_hit", 32'd0, 1'b1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
